pulse_sync_tx: RTL and testbench
================================

# pulse_sync_tx

Source-side (clkA) transmitter for the pulse-synchronised data crossing. Captures an N-bit word on a strobe, holds it stable, and signals it to the clkB receiver with a 2-phase toggle request. Blocks new words until the receiver's toggle acknowledge returns through an on-block synchroniser, and counts strobes dropped while busy.

## Interface
Parameters:
- N, 8, data width
- SYNC_STAGES, 2, flops in the ack synchroniser (legal ≥ 2)
- DROP_W, 8, drop-counter width

Ports:
- clkA  in  1  source clock
- rst_n  in  1  reset, asynchronous, active-low
- enaA  in  1  clock enable; FSM, data and counter registers hold when low
- stb  in  1  single-cycle request to send data_in
- data_in  in  N  word to send, sampled when accepted
- ready  out  1  block idle; stb accepted this cycle
- done  out  1  one-cycle pulse, receiver acknowledged last word
- data_hold  out  N  registered word presented to clkB domain
- req_tgl  out  1  request toggle to clkB domain
- ack_tgl  in  1  acknowledge toggle from clkB domain, asynchronous to clkA
- drop_clr  in  1  synchronous clear of drop_cnt
- drop_cnt  out  DROP_W  saturating count of strobes rejected while busy

## Operation
- States: IDLE, WAIT_ACK. ready = (state == IDLE), combinational from state.
- IDLE, enaA & stb: data_hold <= data_in; req_tgl <= ~req_tgl; state -> WAIT_ACK.
- WAIT_ACK: data_hold and req_tgl frozen. When ack_s (last synchroniser stage) == req_tgl and enaA: state -> IDLE, done <= 1 for one cycle.
- done is 0 in every other cycle, including cycles with enaA low.
- stb while state == WAIT_ACK and enaA: word discarded; drop_cnt += 1, saturating at 2^DROP_W−1.
- drop_clr (enaA high) sets drop_cnt to 0. drop_clr has priority over a simultaneous drop, so the result is 0.
- The ack synchroniser samples every clkA edge regardless of enaA.
- Reset values: state IDLE, ready 1, done 0, data_hold 0, req_tgl 0, synchroniser stages 0, drop_cnt 0.
- Reset mid-transfer: returns to IDLE with req_tgl 0. The receiver must be reset by the same rst_n so ack_tgl also returns to 0. No partial word is retained.

## Timing
- Accept at edge t (stb & ready & enaA): data_hold and req_tgl are new after t. ready is low from t+1.
- data_hold changes only at accept edges, so it is stable for the full WAIT_ACK period. This guarantees the clkB capture sees settled data.
- With ack_tgl toggling at edge a, ack_s matches after SYNC_STAGES clkA edges. State returns to IDLE and done rises at the next edge. ready is high in the same cycle done is high.
- stb in the done cycle is accepted, because ready is already 1.
- stb on the accept edge itself is a single request: no drop is counted.
- Minimum spacing between accepted words: 1 (accept) + receiver turnaround + SYNC_STAGES + 1 clkA cycles.
- enaA low during WAIT_ACK: the match is detected on the first edge with enaA high.

## Structure
- Shared package pulse_sync_pkg holds:
  - the state enum {IDLE, WAIT_ACK};
  - the default SYNC_STAGES = 2, shared with the receiver's req synchroniser.
- Sub-module bit_sync: parameterised SYNC_STAGES flop chain with async active-low reset. It is reused by the clkB receiver for req_tgl.
- Top level contains the FSM, data_hold, req_tgl and drop counter.

## Test plan
- Reset, then one word: data_in=8'hA5, stb at cycle 3. Expect data_hold=A5 and req_tgl=1 at cycle 4, ready=0. A model toggles ack_tgl at cycle 8 → done pulse at cycle 11 (SYNC_STAGES=2), ready=1.
- Back-to-back: stb in the done cycle with 8'h3C → accepted, req_tgl returns to 0, drop_cnt stays 0.
- Busy drops: 3 strobes during WAIT_ACK → drop_cnt=3, data_hold unchanged. Then drop_clr together with a 4th busy strobe → drop_cnt=0.
- Saturation: DROP_W=2, 5 busy strobes → drop_cnt=3.
- enaA gating: enaA low across the ack arrival → no done. done rises one edge after enaA returns high. A stb with enaA low is not accepted and not counted.
- Reset mid-WAIT_ACK: assert rst_n low → ready=1, req_tgl=0, data_hold=0, done=0. A new word after release completes normally.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pulse_sync_pkg
// Purpose : Shared definitions for the pulse-synchronised data crossing.
//           Holds the transmitter state encoding and the default depth of
//           the toggle synchronisers. Both sides of the crossing use this
//           depth.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package pulse_sync_pkg;

    // Transmitter handshake states
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // Default synchroniser depth for both the req and ack toggles
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage : pulse_sync_pkg
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module  : bit_sync
// Purpose : Single-bit multi-flop synchroniser for a level/toggle signal
//           arriving from an asynchronous clock domain.
// Ports   : clk    in  destination clock
//           rst_n  in  asynchronous active-low reset (chain clears to 0)
//           d      in  asynchronous input bit
//           q      out synchronised bit (last stage)
// Rev     : 1.0  initial release
// ============================================================================
module bit_sync
    import pulse_sync_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Stage 0 is the metastability-exposed flop; the last stage is used.
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule : bit_sync
`default_nettype wire

// File: rtl/pulse_sync_tx.sv
`default_nettype none
// ============================================================================
// Module  : pulse_sync_tx
// Purpose : clkA-side transmitter of the pulse-synchronised data crossing.
//           It captures a word on stb and holds it stable on data_hold. It
//           announces the word to clkB by flipping req_tgl. It then waits
//           until the synchronised ack_tgl equals req_tgl. Strobes that
//           arrive while busy are counted in a saturating drop counter.
// Ports   : clkA      in  source clock
//           rst_n     in  asynchronous active-low reset
//           enaA      in  clock enable for FSM, data and counter registers
//           stb       in  request to send data_in
//           data_in   in  [N]      word to send
//           ready     out idle, stb accepted this cycle
//           done      out one-cycle pulse on acknowledge of last word
//           data_hold out [N]      word presented to the clkB domain
//           req_tgl   out request toggle to clkB
//           ack_tgl   in  acknowledge toggle from clkB (asynchronous)
//           drop_clr  in  synchronous clear of drop_cnt
//           drop_cnt  out [DROP_W] saturating count of rejected strobes
// Rev     : 1.0  initial release
// ============================================================================
module pulse_sync_tx
    import pulse_sync_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DROP_W      = 8
) (
    input  logic              clkA,
    input  logic              rst_n,
    input  logic              enaA,
    input  logic              stb,
    input  logic [N-1:0]      data_in,
    output logic              ready,
    output logic              done,
    output logic [N-1:0]      data_hold,
    output logic              req_tgl,
    input  logic              ack_tgl,
    input  logic              drop_clr,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] C_DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] C_DROP_MAX = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_ack_s;
    logic               w_accept;
    logic               w_ack_match;
    logic               w_drop;
    logic               r_done;
    logic [N-1:0]       r_data_hold;
    logic               r_req_tgl;
    logic [DROP_W-1:0]  r_drop_cnt;

    // ------------------------------------------------------------------
    // Ack synchroniser: free-running on clkA, independent of enaA, so the
    // ack edge is never missed while the block is gated off.
    // ------------------------------------------------------------------
    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clkA),
        .rst_n (rst_n),
        .d     (ack_tgl),
        .q     (w_ack_s)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (enaA) begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (stb)                  w_state_next = WAIT_ACK;
            WAIT_ACK: if (w_ack_s == r_req_tgl) w_state_next = IDLE;
            default:                            w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and qualified events
    // ------------------------------------------------------------------
    always_comb begin
        ready       = (r_state == IDLE);
        w_accept    = 1'b0;
        w_ack_match = 1'b0;
        w_drop      = 1'b0;
        if (enaA) begin
            w_accept    = stb && (r_state == IDLE);
            w_drop      = stb && (r_state == WAIT_ACK);
            w_ack_match = (r_state == WAIT_ACK) && (w_ack_s == r_req_tgl);
        end
    end

    // ------------------------------------------------------------------
    // done is not gated by enaA. It falls back to 0 on the next edge
    // even when the block is disabled.
    // ------------------------------------------------------------------
    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_ack_match;
        end
    end

    // ------------------------------------------------------------------
    // Data and request toggle. These change only on an accept edge, so
    // data_hold is stable for the whole WAIT_ACK period.
    // ------------------------------------------------------------------
    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            r_data_hold <= '0;
            r_req_tgl   <= 1'b0;
        end else if (w_accept) begin
            r_data_hold <= data_in;
            r_req_tgl   <= ~r_req_tgl;
        end
    end

    // ------------------------------------------------------------------
    // Drop counter: clear wins over a simultaneous drop; saturates at max
    // ------------------------------------------------------------------
    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (enaA) begin
            if (drop_clr) begin
                r_drop_cnt <= '0;
            end else if (w_drop && (r_drop_cnt != C_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + C_DROP_ONE;
            end
        end
    end

    assign done      = r_done;
    assign data_hold = r_data_hold;
    assign req_tgl   = r_req_tgl;
    assign drop_cnt  = r_drop_cnt;

endmodule : pulse_sync_tx
`default_nettype wire

// File: tb/tb_pulse_sync_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_pulse_sync_tx
// Purpose : Directed self-checking bench for pulse_sync_tx. Two instances
//           share the same stimulus. One uses the default configuration.
//           The other uses DROP_W=2 so that drop-counter saturation can be
//           observed.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pulse_sync_tx;

    logic       clkA = 1'b0;
    logic       rst_n;
    logic       enaA;
    logic       stb;
    logic [7:0] data_in;
    logic       ack_tgl;
    logic       drop_clr;

    logic       ready,     ready_s;
    logic       done,      done_s;
    logic [7:0] data_hold, data_hold_s;
    logic       req_tgl,   req_tgl_s;
    logic [7:0] drop_cnt;
    logic [1:0] drop_cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clkA = ~clkA;

    pulse_sync_tx #(.N(8), .SYNC_STAGES(2), .DROP_W(8)) u_dut (
        .clkA      (clkA),
        .rst_n     (rst_n),
        .enaA      (enaA),
        .stb       (stb),
        .data_in   (data_in),
        .ready     (ready),
        .done      (done),
        .data_hold (data_hold),
        .req_tgl   (req_tgl),
        .ack_tgl   (ack_tgl),
        .drop_clr  (drop_clr),
        .drop_cnt  (drop_cnt)
    );

    pulse_sync_tx #(.N(8), .SYNC_STAGES(2), .DROP_W(2)) u_dut_sat (
        .clkA      (clkA),
        .rst_n     (rst_n),
        .enaA      (enaA),
        .stb       (stb),
        .data_in   (data_in),
        .ready     (ready_s),
        .done      (done_s),
        .data_hold (data_hold_s),
        .req_tgl   (req_tgl_s),
        .ack_tgl   (ack_tgl),
        .drop_clr  (drop_clr),
        .drop_cnt  (drop_cnt_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 time
    // unit after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clkA);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d);
        stb     = 1'b1;
        data_in = d;
        tick();
        stb     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enaA = 1'b1; stb = 1'b0; data_in = '0;
        ack_tgl = 1'b0; drop_clr = 1'b0;
        tick(3);

        // ---------------- reset state ----------------
        check_eq("rst_ready",    ready,     1);
        check_eq("rst_done",     done,      0);
        check_eq("rst_data",     data_hold, 8'h00);
        check_eq("rst_req",      req_tgl,   0);
        check_eq("rst_drop",     drop_cnt,  0);
        rst_n = 1'b1;
        tick(2);

        // ---------------- single word ----------------
        send(8'hA5);
        check_eq("acc_data",  data_hold, 8'hA5);
        check_eq("acc_req",   req_tgl,   1);
        check_eq("acc_ready", ready,     0);
        tick(3);
        check_eq("wait_ready", ready, 0);
        ack_tgl = 1'b1;
        tick();
        check_eq("ack_e1_done", done, 0);
        tick();
        check_eq("ack_e2_done", done, 0);
        check_eq("ack_e2_ready", ready, 0);
        tick();
        check_eq("ack_done",  done,  1);
        check_eq("ack_ready", ready, 1);

        // ---------------- back-to-back in done cycle ----------------
        send(8'h3C);
        check_eq("b2b_data",  data_hold, 8'h3C);
        check_eq("b2b_req",   req_tgl,   0);
        check_eq("b2b_ready", ready,     0);
        check_eq("b2b_done",  done,      0);
        check_eq("b2b_drop",  drop_cnt,  0);

        // ---------------- busy drops ----------------
        for (int i = 0; i < 3; i++) begin
            send(8'hEE);
            tick();
        end
        check_eq("drop3_cnt",  drop_cnt,  3);
        check_eq("drop3_data", data_hold, 8'h3C);
        stb = 1'b1; drop_clr = 1'b1; data_in = 8'h11;
        tick();
        stb = 1'b0; drop_clr = 1'b0;
        check_eq("clr_prio_cnt", drop_cnt, 0);
        check_eq("clr_data",     data_hold, 8'h3C);
        ack_tgl = 1'b0;
        tick(3);
        check_eq("ack2_done", done, 1);
        tick();
        check_eq("ack2_done_fall", done, 0);

        // ---------------- saturation ----------------
        send(8'h5A);
        check_eq("sat_req", req_tgl, 1);
        for (int i = 0; i < 5; i++) begin
            send(8'h00);
        end
        check_eq("sat_cnt_w8", drop_cnt,   5);
        check_eq("sat_cnt_w2", drop_cnt_s, 3);
        check_eq("sat_data",   data_hold_s, 8'h5A);
        ack_tgl = 1'b1;
        tick(3);
        check_eq("ack3_done", done, 1);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check_eq("clr_w8", drop_cnt,   0);
        check_eq("clr_w2", drop_cnt_s, 0);

        // ---------------- enaA gating ----------------
        send(8'hC3);
        check_eq("ena_req", req_tgl, 0);
        enaA    = 1'b0;
        ack_tgl = 1'b0;
        tick(4);
        check_eq("ena_low_done",  done,  0);
        check_eq("ena_low_ready", ready, 0);
        send(8'h77);
        check_eq("ena_low_nodrop", drop_cnt, 0);
        check_eq("ena_low_done2",  done,     0);
        enaA = 1'b1;
        tick();
        check_eq("ena_high_done",  done,  1);
        check_eq("ena_high_ready", ready, 1);
        enaA = 1'b0;
        send(8'hFF);
        check_eq("ena_idle_ready", ready,     1);
        check_eq("ena_idle_data",  data_hold, 8'hC3);
        check_eq("ena_idle_req",   req_tgl,   0);
        check_eq("ena_idle_done",  done,      0);
        enaA = 1'b1;
        tick();

        // ---------------- reset mid-WAIT_ACK ----------------
        send(8'h77);
        check_eq("mid_req", req_tgl, 1);
        tick();
        rst_n   = 1'b0;
        ack_tgl = 1'b0;
        #1;
        check_eq("mid_rst_ready", ready,     1);
        check_eq("mid_rst_req",   req_tgl,   0);
        check_eq("mid_rst_data",  data_hold, 8'h00);
        check_eq("mid_rst_done",  done,      0);
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h99);
        check_eq("post_data", data_hold, 8'h99);
        check_eq("post_req",  req_tgl,   1);
        ack_tgl = 1'b1;
        tick(2);
        check_eq("post_e2_done", done, 0);
        tick();
        check_eq("post_done", done, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pulse_sync_tx
`default_nettype wire
